// File: rtl/bram_pixel_streamer.sv
// rtl/bram_pixel_streamer.sv - frame-buffer read engine: BRAM address sweep to valid/ready pixel stream
// Credit-based issue keeps FIFO occupancy plus in-flight reads within FIFO_DEPTH, so no read is ever dropped.
module bram_pixel_streamer #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 18,
  parameter int READ_LAT = 1
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              dir,
  input  logic              abort,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  localparam int FIFO_DEPTH = READ_LAT + 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 2) + 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [PW-1:0]     PTR_LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic [READ_LAT-1:0] pipe;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W:0]   remaining, len_r, beat_idx;
  logic              dir_r;
  logic [CW-1:0]     inflight, outstanding;
  logic              pop, push, credit;

  // ena itself counts as the youngest in-flight read
  always_comb begin
    inflight = CW'(ena);
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + CW'(pipe[i]);
  end

  assign pop         = m_valid & m_ready;
  assign push        = pipe[READ_LAT-1];
  assign outstanding = fifo_count + inflight - CW'(pop);
  assign credit      = outstanding < CW'(FIFO_DEPTH);

  assign m_valid = fifo_count != '0;
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && (beat_idx == len_r - LEN_ONE);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ena        <= 1'b0;
      addra      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      next_addr  <= '0;
      remaining  <= '0;
      len_r      <= '0;
      beat_idx   <= '0;
      dir_r      <= 1'b0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (abort) begin
      state      <= IDLE;
      ena        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pipe       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      pipe <= READ_LAT'({pipe, ena});

      if (push) begin
        mem[wr_ptr] <= douta;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        beat_idx <= beat_idx + LEN_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase

      done <= 1'b0;
      case (state)
        IDLE: begin
          ena <= 1'b0;
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              ena       <= 1'b1;
              addra     <= base;
              next_addr <= dir ? base - ADDR_ONE : base + ADDR_ONE;
              remaining <= len - LEN_ONE;
              len_r     <= len;
              dir_r     <= dir;
              beat_idx  <= '0;
            end
          end
        end
        RUN: begin
          if (remaining == '0) begin
            ena   <= 1'b0;
            state <= DRAIN;
          end else if (credit) begin
            ena       <= 1'b1;
            addra     <= next_addr;
            next_addr <= dir_r ? next_addr - ADDR_ONE : next_addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
          end else begin
            ena <= 1'b0;
          end
        end
        DRAIN: begin
          ena <= 1'b0;
          // last beat popping this edge with nothing else in flight ends the run
          if (outstanding == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// tb/tb_bram_pixel_streamer.sv - scoreboard bench driving READ_LAT=1 and READ_LAT=3 instances in lockstep
`timescale 1ns/1ps
module tb_bram_pixel_streamer;
  localparam int DW = 24;
  localparam int AW = 18;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          dir;
    bit            rnd;
    bit            dup;
    logic [DW-1:0] exp_last;
  } run_t;

  logic          clka = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          dir = 1'b0;
  logic          abort = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;

  logic          ena1, m_valid1, m_last1, busy1, done1;
  logic [AW-1:0] addra1;
  logic [DW-1:0] douta1, m_data1;
  logic          ena3, m_valid3, m_last3, busy3, done3;
  logic [AW-1:0] addra3;
  logic [DW-1:0] douta3, m_data3;

  int checks = 0;
  int errors = 0;

  always #5 clka = ~clka;

  bram_pixel_streamer #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_lat1 (
    .clka(clka), .rst(rst), .start(start), .base(base), .len(len), .dir(dir), .abort(abort),
    .ena(ena1), .addra(addra1), .douta(douta1), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_last(m_last1), .busy(busy1), .done(done1));

  bram_pixel_streamer #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(3)) u_lat3 (
    .clka(clka), .rst(rst), .start(start), .base(base), .len(len), .dir(dir), .abort(abort),
    .ena(ena3), .addra(addra3), .douta(douta3), .m_valid(m_valid3), .m_ready(m_ready),
    .m_data(m_data3), .m_last(m_last3), .busy(busy3), .done(done3));

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return {6'd0, a};
  endfunction

  // BRAM models: pixel at address a is simply a
  always @(posedge clka) if (ena1) douta1 <= pix(addra1);
  logic [DW-1:0] rd3 [3];
  always @(posedge clka) begin
    if (ena3) rd3[0] <= pix(addra3);
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end
  assign douta3 = rd3[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  beat_t         q1[$];
  beat_t         q3[$];
  int            lat_of [2] = '{1, 3};
  int            iss [2];
  int            pops [2];
  bit            stall [2];
  logic [DW-1:0] hold_d [2];
  logic          hold_l [2];
  logic [DW-1:0] last_seen [2];

  task automatic mon(input int k, input logic e, input logic v, input logic [DW-1:0] d,
                     input logic l, input logic b);
    beat_t x;
    bit    have;
    if (rst || abort) begin
      iss[k] = 0; pops[k] = 0; stall[k] = 0;
      return;
    end
    if (e) iss[k]++;
    if (b) chk($sformatf("outstanding_le_depth_lat%0d", lat_of[k]),
               32'(iss[k] - pops[k] <= lat_of[k] + 2), 32'd1);
    if (stall[k]) begin
      chk($sformatf("stall_valid_lat%0d", lat_of[k]), 32'(v), 32'd1);
      chk($sformatf("stall_data_lat%0d", lat_of[k]), 32'(d), 32'(hold_d[k]));
      chk($sformatf("stall_last_lat%0d", lat_of[k]), 32'(l), 32'(hold_l[k]));
    end
    if (v && m_ready) begin
      have = (k == 0) ? (q1.size() != 0) : (q3.size() != 0);
      if (!have) begin
        checks++; errors++;
        $display("FAIL unexpected_beat_lat%0d: got data 0x%0h expected no beat", lat_of[k], d);
      end else begin
        if (k == 0) x = q1.pop_front();
        else        x = q3.pop_front();
        chk($sformatf("beat_data_lat%0d", lat_of[k]), 32'(d), 32'(x.data));
        chk($sformatf("beat_last_lat%0d", lat_of[k]), 32'(l), 32'(x.last));
      end
      if (l) last_seen[k] = d;
      pops[k]++;
    end
    stall[k]  = v && !m_ready;
    hold_d[k] = d;
    hold_l[k] = l;
  endtask

  initial forever begin
    @(negedge clka);
    mon(0, ena1, m_valid1, m_data1, m_last1, busy1);
    mon(1, ena3, m_valid3, m_data3, m_last3, busy3);
  end

  task automatic push_exp(input logic [AW-1:0] b, input logic [AW:0] n, input logic d);
    beat_t         bt;
    logic [AW-1:0] a;
    for (int i = 0; i < int'(n); i++) begin
      a       = d ? b - AW'(i) : b + AW'(i);
      bt.data = pix(a);
      bt.last = (i == int'(n) - 1);
      q1.push_back(bt);
      q3.push_back(bt);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ena"},     32'({ena1, ena3}), 32'd0);
    chk({tag, "_addra1"},  32'(addra1), 32'd0);
    chk({tag, "_addra3"},  32'(addra3), 32'd0);
    chk({tag, "_m_valid"}, 32'({m_valid1, m_valid3}), 32'd0);
    chk({tag, "_m_data1"}, 32'(m_data1), 32'd0);
    chk({tag, "_m_data3"}, 32'(m_data3), 32'd0);
    chk({tag, "_m_last"},  32'({m_last1, m_last3}), 32'd0);
    chk({tag, "_busy"},    32'({busy1, busy3}), 32'd0);
    chk({tag, "_done"},    32'({done1, done3}), 32'd0);
  endtask

  task automatic do_run(input run_t r);
    int  first [2];
    int  dn [2];
    int  dcyc [2];
    int  c;
    bit  fin;
    for (int k = 0; k < 2; k++) begin
      first[k] = -1; dn[k] = 0; dcyc[k] = -1; last_seen[k] = '0;
    end
    push_exp(r.base, r.len, r.dir);
    base = r.base; len = r.len; dir = r.dir; start = 1'b1;
    @(posedge clka); #1;
    start   = 1'b0;
    m_ready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    c   = 0;
    fin = 0;
    while (!fin) begin
      @(negedge clka);
      if (c == 0) begin
        chk("e0_busy",   32'({busy1, busy3}), 32'b11);
        chk("e0_ena",    32'({ena1, ena3}), 32'b11);
        chk("e0_addra1", 32'(addra1), 32'(r.base));
        chk("e0_addra3", 32'(addra3), 32'(r.base));
      end
      if (m_valid1 && first[0] < 0) first[0] = c;
      if (m_valid3 && first[1] < 0) first[1] = c;
      if (done1) begin dn[0]++; dcyc[0] = c; end
      if (done3) begin dn[1]++; dcyc[1] = c; end
      if (dn[0] > 0 && dn[1] > 0 && c >= dcyc[0] + 2 && c >= dcyc[1] + 2) fin = 1;
      if (c >= 400) begin
        checks++; errors++;
        $display("FAIL run_timeout: got done counts %0d/%0d expected 1/1 within 400 cycles", dn[0], dn[1]);
        fin = 1;
      end
      c++;
      @(posedge clka); #1;
      m_ready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (r.dup && c == 3) begin
        start = 1'b1; base = 18'd900; len = 19'd3; dir = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("queue1_drained", 32'(q1.size()), 32'd0);
    chk("queue3_drained", 32'(q3.size()), 32'd0);
    chk("done_once_lat1", 32'(dn[0]), 32'd1);
    chk("done_once_lat3", 32'(dn[1]), 32'd1);
    chk("last_beat_lat1", 32'(last_seen[0]), 32'(r.exp_last));
    chk("last_beat_lat3", 32'(last_seen[1]), 32'(r.exp_last));
    chk("busy_after",     32'({busy1, busy3}), 32'd0);
    if (!r.rnd) begin
      chk("first_valid_lat1", 32'(first[0]), 32'd2);
      chk("first_valid_lat3", 32'(first[1]), 32'd4);
      chk("done_cycle_lat1",  32'(dcyc[0]), 32'(int'(r.len) + 2));
      chk("done_cycle_lat3",  32'(dcyc[1]), 32'(int'(r.len) + 4));
    end
  endtask

  initial begin
    run_t tbl [7];
    int   bad;
    tbl[0] = '{18'd0,       19'd8,  1'b0, 1'b0, 1'b0, 24'h000007};
    tbl[1] = '{18'd5,       19'd6,  1'b1, 1'b0, 1'b0, 24'h000000};
    tbl[2] = '{18'd2,       19'd4,  1'b1, 1'b0, 1'b0, 24'h03FFFF};
    tbl[3] = '{18'h3FFFE,   19'd4,  1'b0, 1'b0, 1'b0, 24'h000001};
    tbl[4] = '{18'd100,     19'd16, 1'b0, 1'b1, 1'b0, 24'h000073};
    tbl[5] = '{18'd7,       19'd1,  1'b1, 1'b1, 1'b0, 24'h000007};
    tbl[6] = '{18'd20,      19'd5,  1'b0, 1'b0, 1'b1, 24'h000018};

    repeat (3) @(posedge clka);
    @(negedge clka);
    chk_reset_outputs("reset");
    @(posedge clka); #1;
    rst = 1'b0;
    m_ready = 1'b1;

    for (int i = 0; i < 7; i++) do_run(tbl[i]);

    // len=0: done next cycle, no beats, busy never rises
    base = 18'd33; len = '0; dir = 1'b0; start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    @(negedge clka);
    chk("len0_done",  32'({done1, done3}), 32'b11);
    chk("len0_busy",  32'({busy1, busy3}), 32'd0);
    chk("len0_valid", 32'({m_valid1, m_valid3}), 32'd0);
    @(negedge clka);
    chk("len0_done_pulse", 32'({done1, done3}), 32'd0);
    @(posedge clka); #1;

    // abort while lat1 presents beat 3 of a 10-pixel run
    push_exp(18'd40, 19'd10, 1'b0);
    base = 18'd40; len = 19'd10; dir = 1'b0; start = 1'b1; m_ready = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (5) @(posedge clka);
    #1 abort = 1'b1;
    @(negedge clka);
    chk("abort_beat3_valid", 32'(m_valid1), 32'd1);
    chk("abort_beat3_data",  32'(m_data1), 32'(pix(18'd43)));
    @(posedge clka); #1;
    abort = 1'b0;
    q1.delete(); q3.delete();
    @(negedge clka);
    chk("abort_valid", 32'({m_valid1, m_valid3}), 32'd0);
    chk("abort_busy",  32'({busy1, busy3}), 32'd0);
    bad = 0;
    repeat (8) begin
      @(negedge clka);
      if (done1 || done3 || m_valid1 || m_valid3) bad++;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    @(posedge clka); #1;
    do_run('{18'd300, 19'd2, 1'b1, 1'b0, 1'b0, 24'h00012B});

    // asynchronous reset mid-run with reads in flight and the stream stalled
    push_exp(18'd60, 19'd12, 1'b0);
    base = 18'd60; len = 19'd12; dir = 1'b0; start = 1'b1; m_ready = 1'b0;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (2) @(posedge clka);
    @(negedge clka);
    #1 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    @(negedge clka);
    @(posedge clka); #1;
    rst = 1'b0;
    q1.delete(); q3.delete();
    m_ready = 1'b1;
    do_run('{18'h01234, 19'd1, 1'b0, 1'b0, 1'b0, 24'h001234});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish within 1 ms");
    $fatal(1, "watchdog");
  end

endmodule
